fc_layer_engine: RTL and testbench



---
 rtl/fc_layer_engine.sv | 197 +++++++++++++++++++
 tb/tb_fc_layer_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: one multiply-accumulate per cycle over N_IN
// input/weight pairs per neuron, bias preload, floor-shift back to DATA_W,
// saturation, optional ReLU, result write-out and running argmax tracking.
// Memories are external with one-cycle synchronous read latency; every
// address is issued one cycle before its data is consumed.
module fc_layer_engine #(
   parameter int N_IN      = 60,
   parameter int N_OUT     = 48,
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 16,
   parameter int RELU_EN   = 1,
   localparam int IN_AW    = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int OUT_AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int W_AW     = ((N_IN * N_OUT) > 1) ? $clog2(N_IN * N_OUT) : 1,
   localparam int ACC_W    = 2 * DATA_W + $clog2(N_IN) + 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [DATA_W-1:0] weight,
   input  logic signed [DATA_W-1:0] bias,
   output logic [IN_AW-1:0]         in_addr,
   output logic [W_AW-1:0]          weight_addr,
   output logic [OUT_AW-1:0]        bias_addr,
   output logic [OUT_AW-1:0]        out_addr,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_wren,
   output logic                     busy,
   output logic                     done,
   output logic [OUT_AW-1:0]        max_idx,
   output logic signed [DATA_W-1:0] max_val
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BIAS  = 3'd1,
      S_MAC   = 3'd2,
      S_FLUSH = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Counter limits and steps, sized to their registers so the compares stay width-clean.
   localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(N_IN - 1);
   localparam logic [IN_AW-1:0]  K_ONE  = IN_AW'(1);
   localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(N_OUT - 1);
   localparam logic [OUT_AW-1:0] N_ONE  = OUT_AW'(1);
   localparam logic [W_AW-1:0]   W_STEP = W_AW'(N_IN);

   // Representable result range, expressed at accumulator width for signed compares.
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t                     state_r;
   logic [OUT_AW-1:0]          n_r;
   logic [IN_AW-1:0]           k_r;
   logic [W_AW-1:0]            w_base_r;   // n*N_IN, advanced by N_IN per neuron
   logic signed [ACC_W-1:0]    acc_r;

   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [ACC_W-1:0]    prod_ext_s;
   logic signed [ACC_W-1:0]    bias_ext_s;
   logic signed [ACC_W-1:0]    acc_sum_s;
   logic [IN_AW-1:0]           k_nxt_s;

   // Floor-shift the accumulator back to DATA_W, clamp to range, then apply ReLU.
   function automatic logic signed [DATA_W-1:0] finish_result(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0]  sh;
      logic signed [DATA_W-1:0] r;
      sh = a >>> FRAC_BITS;
      if (sh > SAT_MAX) begin
         r = SAT_MAX[DATA_W-1:0];
      end else if (sh < SAT_MIN) begin
         r = SAT_MIN[DATA_W-1:0];
      end else begin
         r = sh[DATA_W-1:0];
      end
      if ((RELU_EN != 0) && r[DATA_W-1]) begin
         r = {DATA_W{1'b0}};
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Full-precision product, bias alignment and the running sum fed to the accumulator.
   always_comb begin
      prod_s     = $signed({{DATA_W{in_data[DATA_W-1]}}, in_data})
                 * $signed({{DATA_W{weight[DATA_W-1]}}, weight});
      prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
      bias_ext_s = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;
      acc_sum_s  = acc_r + prod_ext_s;
      k_nxt_s    = k_r + K_ONE;
   end

   // Sequencer: walks BIAS/MAC/FLUSH/WRITE per neuron and owns every registered output.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r     <= S_IDLE;
         n_r         <= {OUT_AW{1'b0}};
         k_r         <= {IN_AW{1'b0}};
         w_base_r    <= {W_AW{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         in_addr     <= {IN_AW{1'b0}};
         weight_addr <= {W_AW{1'b0}};
         bias_addr   <= {OUT_AW{1'b0}};
         out_addr    <= {OUT_AW{1'b0}};
         out_data    <= {DATA_W{1'b0}};
         out_wren    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         max_idx     <= {OUT_AW{1'b0}};
         max_val     <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  n_r         <= {OUT_AW{1'b0}};
                  k_r         <= {IN_AW{1'b0}};
                  w_base_r    <= {W_AW{1'b0}};
                  bias_addr   <= {OUT_AW{1'b0}};
                  in_addr     <= {IN_AW{1'b0}};
                  weight_addr <= {W_AW{1'b0}};
                  busy        <= 1'b1;
                  state_r     <= S_BIAS;
               end else begin
                  busy        <= 1'b0;
               end
            end
            S_BIAS: begin
               // Bias address was presented this cycle; pair 0 is requested next.
               k_r         <= {IN_AW{1'b0}};
               in_addr     <= {IN_AW{1'b0}};
               weight_addr <= w_base_r;
               state_r     <= S_MAC;
            end
            S_MAC: begin
               // Data arriving now belongs to the address issued one cycle earlier.
               if (k_r == {IN_AW{1'b0}}) begin
                  acc_r <= bias_ext_s;
               end else begin
                  acc_r <= acc_sum_s;
               end
               if (k_r == K_LAST) begin
                  state_r <= S_FLUSH;
               end else begin
                  k_r         <= k_nxt_s;
                  in_addr     <= k_nxt_s;
                  weight_addr <= w_base_r + W_AW'(k_nxt_s);
               end
            end
            S_FLUSH: begin
               // Last pair completes the sum; result is registered for the WRITE cycle.
               acc_r    <= acc_sum_s;
               out_data <= finish_result(acc_sum_s);
               out_addr <= n_r;
               out_wren <= 1'b1;
               state_r  <= S_WRITE;
            end
            S_WRITE: begin
               out_wren <= 1'b0;
               // Strict compare keeps the lowest index on ties.
               if ((n_r == {OUT_AW{1'b0}}) || (out_data > max_val)) begin
                  max_val <= out_data;
                  max_idx <= n_r;
               end else begin
                  max_val <= max_val;
               end
               if (n_r == N_LAST) begin
                  done    <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  n_r         <= n_r + N_ONE;
                  w_base_r    <= w_base_r + W_STEP;
                  bias_addr   <= n_r + N_ONE;
                  in_addr     <= {IN_AW{1'b0}};
                  weight_addr <= w_base_r + W_STEP;
                  state_r     <= S_BIAS;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               out_wren <= 1'b0;
               done     <= 1'b0;
               busy     <= 1'b0;
               state_r  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Testbench for fc_layer_engine: two 4x4 engines (ReLU on/off) share one set
// of memories, a third 1x3 engine exercises the single-input case. A
// behavioural model computes every neuron result from the memory contents
// and a per-cycle checker compares timing, addresses, writes and argmax.
module tb_fc_layer_engine;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   logic start_a = 1'b0;
   logic start_p = 1'b0;

   logic signed [15:0] in_a = 16'sd0, w_a = 16'sd0, b_a = 16'sd0;
   logic signed [15:0] in_p = 16'sd0, w_p = 16'sd0, b_p = 16'sd0;

   logic [1:0] r_in_addr, r_b_addr, r_o_addr, r_mi;
   logic [3:0] r_w_addr;
   logic signed [15:0] r_o_data, r_mv;
   logic r_wr, r_busy, r_done;

   logic [1:0] s_in_addr, s_b_addr, s_o_addr, s_mi;
   logic [3:0] s_w_addr;
   logic signed [15:0] s_o_data, s_mv;
   logic s_wr, s_busy, s_done;

   logic [0:0] p_in_addr;
   logic [1:0] p_w_addr, p_b_addr, p_o_addr, p_mi;
   logic signed [15:0] p_o_data, p_mv;
   logic p_wr, p_busy, p_done;

   fc_layer_engine #(.N_IN(4), .N_OUT(4), .DATA_W(16), .FRAC_BITS(8), .RELU_EN(1)) dut_r (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_a),
      .in_data(in_a), .weight(w_a), .bias(b_a),
      .in_addr(r_in_addr), .weight_addr(r_w_addr), .bias_addr(r_b_addr),
      .out_addr(r_o_addr), .out_data(r_o_data), .out_wren(r_wr),
      .busy(r_busy), .done(r_done), .max_idx(r_mi), .max_val(r_mv));

   fc_layer_engine #(.N_IN(4), .N_OUT(4), .DATA_W(16), .FRAC_BITS(8), .RELU_EN(0)) dut_s (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_a),
      .in_data(in_a), .weight(w_a), .bias(b_a),
      .in_addr(s_in_addr), .weight_addr(s_w_addr), .bias_addr(s_b_addr),
      .out_addr(s_o_addr), .out_data(s_o_data), .out_wren(s_wr),
      .busy(s_busy), .done(s_done), .max_idx(s_mi), .max_val(s_mv));

   fc_layer_engine #(.N_IN(1), .N_OUT(3), .DATA_W(16), .FRAC_BITS(8), .RELU_EN(0)) dut_p (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_p),
      .in_data(in_p), .weight(w_p), .bias(b_p),
      .in_addr(p_in_addr), .weight_addr(p_w_addr), .bias_addr(p_b_addr),
      .out_addr(p_o_addr), .out_data(p_o_data), .out_wren(p_wr),
      .busy(p_busy), .done(p_done), .max_idx(p_mi), .max_val(p_mv));

   // Memory images: A = 4 inputs x 4 neurons, B = 1 input x 3 neurons.
   int ina[4], wa[16], ba[4];
   int inb[1], wb[3], bb[3];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc[3]      = '{-1, -1, -1};
   int wr_cnt[3]   = '{0, 0, 0};
   int done_cyc[3] = '{0, 0, 0};
   longint exp_idx[3] = '{0, 0, 0};
   longint exp_val[3] = '{0, 0, 0};
   int got[3][4];

   initial forever #5 Clk = ~Clk;

   task automatic cmp(input string nm, input int id, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", nm, id, $time, act, exp);
      end
   endtask

   // Reference result of neuron n: exact sum, floor divide by 2^8, clamp, optional ReLU.
   function automatic longint model_res(input int id, input int n);
      longint acc, r;
      if (id == 2) begin
         acc = longint'(bb[n]) * 256 + longint'(inb[0]) * longint'(wb[n]);
      end else begin
         acc = longint'(ba[n]) * 256;
         for (int k = 0; k < 4; k++) acc += longint'(ina[k]) * longint'(wa[n*4+k]);
      end
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (id == 0 && r < 0) r = 0;
      return r;
   endfunction

   task automatic check_dut(input int id, input integer ia, input integer wadr, input integer badr,
                            input integer oa, input integer od, input logic wr, input logic bz,
                            input logic dn, input integer mi, input integer mv);
      int ni, no, per, last, c, j, p, k;
      longint r;
      logic exp_wr;
      ni = (id == 2) ? 1 : 4;
      no = (id == 2) ? 3 : 4;
      per = ni + 3;
      last = no * per;
      c = cyc[id];
      exp_wr = 1'b0;
      if (c >= 1 && c <= last) begin
         j = (c - 1) / per;
         p = (c - 1) % per;
         if (p <= ni) begin
            k = (p == 0) ? 0 : p - 1;
            cmp("in_addr", id, ia, k);
            cmp("weight_addr", id, wadr, j * ni + k);
            cmp("bias_addr", id, badr, j);
         end
         if (p == per - 1) begin
            exp_wr = 1'b1;
            r = model_res(id, j);
            cmp("out_addr", id, oa, j);
            cmp("out_data", id, od, r);
            got[id][j] = od;
            wr_cnt[id]++;
            if (j == 0 || r > exp_val[id]) begin
               exp_val[id] = r;
               exp_idx[id] = j;
            end
         end
      end else begin
         cmp("max_idx", id, mi, exp_idx[id]);
         cmp("max_val", id, mv, exp_val[id]);
      end
      cmp("out_wren", id, wr, exp_wr);
      cmp("done", id, dn, c == last + 1);
      cmp("busy", id, bz, c >= 1 && c <= last + 1);
      if (c == last + 1) begin
         cmp("write_count", id, wr_cnt[id], no);
         done_cyc[id] = c;
      end
   endtask

   task automatic chk_rst(input int id, input integer ia, input integer wadr, input integer badr,
                          input integer oa, input integer od, input logic wr, input logic bz,
                          input logic dn, input integer mi, input integer mv);
      cmp("rst_in_addr", id, ia, 0);
      cmp("rst_weight_addr", id, wadr, 0);
      cmp("rst_bias_addr", id, badr, 0);
      cmp("rst_out_addr", id, oa, 0);
      cmp("rst_out_data", id, od, 0);
      cmp("rst_out_wren", id, wr, 0);
      cmp("rst_busy", id, bz, 0);
      cmp("rst_done", id, dn, 0);
      cmp("rst_max_idx", id, mi, 0);
      cmp("rst_max_val", id, mv, 0);
   endtask

   // Synchronous-read memories: address sampled at the edge, data valid in the following cycle.
   initial forever begin
      int a_i, a_w, a_b, p_w, p_b;
      @(posedge Clk);
      a_i = int'(r_in_addr); a_w = int'(r_w_addr); a_b = int'(r_b_addr);
      p_w = int'(p_w_addr);  p_b = int'(p_b_addr);
      #1;
      in_a = 16'(ina[a_i]); w_a = 16'(wa[a_w]); b_a = 16'(ba[a_b]);
      in_p = 16'(inb[0]);   w_p = 16'(wb[p_w]); b_p = 16'(bb[p_b]);
   end

   // Per-cycle compare processes, one per engine.
   initial forever begin
      @(negedge Clk);
      if (cyc[0] >= 0) cyc[0]++;
      check_dut(0, r_in_addr, r_w_addr, r_b_addr, r_o_addr, r_o_data, r_wr, r_busy, r_done, r_mi, r_mv);
   end
   initial forever begin
      @(negedge Clk);
      if (cyc[1] >= 0) cyc[1]++;
      check_dut(1, s_in_addr, s_w_addr, s_b_addr, s_o_addr, s_o_data, s_wr, s_busy, s_done, s_mi, s_mv);
   end
   initial forever begin
      @(negedge Clk);
      if (cyc[2] >= 0) cyc[2]++;
      check_dut(2, p_in_addr, p_w_addr, p_b_addr, p_o_addr, p_o_data, p_wr, p_busy, p_done, p_mi, p_mv);
   end

   function automatic int rnd(input bit big);
      return big ? (int'($urandom_range(0, 65535)) - 32768) : (int'($urandom_range(0, 1023)) - 512);
   endfunction

   // One layer pass on group A (grp 0) or B (grp 1); optional extra start pulse and mid-pass reset.
   task automatic run_pass(input int grp, input int pulse_at, input int abort_at);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 4; n++) got[i][n] = 99999;
      end
      @(negedge Clk);
      if (grp == 0) start_a = 1'b1; else start_p = 1'b1;
      @(posedge Clk);
      #1;
      start_a = 1'b0; start_p = 1'b0;
      if (grp == 0) begin
         cyc[0] = 0; cyc[1] = 0; wr_cnt[0] = 0; wr_cnt[1] = 0;
      end else begin
         cyc[2] = 0; wr_cnt[2] = 0;
      end
      for (int i = 1; i <= 200; i++) begin
         @(negedge Clk);
         if (grp == 0) start_a = (i == pulse_at); else start_p = (i == pulse_at);
         if (i == abort_at) begin
            @(posedge Clk);
            #2 Reset_n = 1'b0;
            #1;
            chk_rst(0, r_in_addr, r_w_addr, r_b_addr, r_o_addr, r_o_data, r_wr, r_busy, r_done, r_mi, r_mv);
            chk_rst(1, s_in_addr, s_w_addr, s_b_addr, s_o_addr, s_o_data, s_wr, s_busy, s_done, s_mi, s_mv);
            for (int d = 0; d < 3; d++) begin
               cyc[d] = -1; exp_idx[d] = 0; exp_val[d] = 0;
            end
            repeat (3) @(negedge Clk);
            Reset_n = 1'b1;
            ok = 1'b1;
            break;
         end
         if ((grp == 0) ? r_done : p_done) begin
            ok = 1'b1;
            break;
         end
      end
      start_a = 1'b0; start_p = 1'b0;
      if (!ok) cmp("done_timeout", grp, 0, 1);
      repeat (3) @(negedge Clk);
   endtask

   initial begin
      int res4[4];
      for (int n = 0; n < 4; n++) begin ina[n] = 0; ba[n] = 0; end
      for (int n = 0; n < 16; n++) wa[n] = 0;
      inb[0] = 0;
      for (int n = 0; n < 3; n++) begin wb[n] = 0; bb[n] = 0; end
      #1 Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      // Basic MAC: 4*(1.0*0.5)+0.25 = 2.25 -> 576.
      for (int n = 0; n < 4; n++) begin ina[n] = 256; ba[n] = 64; end
      for (int n = 0; n < 16; n++) wa[n] = 128;
      run_pass(0, 0, 0);
      for (int n = 0; n < 4; n++) begin
         cmp("lit_basic_relu", 0, got[0][n], 576);
         cmp("lit_basic_signed", 1, got[1][n], 576);
      end
      cmp("lit_basic_done_cycle", 0, done_cyc[0], 29);
      cmp("lit_basic_max_idx", 0, r_mi, 0);
      cmp("lit_basic_max_val", 0, r_mv, 576);

      // Sign / ReLU: 4*(1.0*-1.0) = -4.0 -> -1024, clamped to 0 with ReLU.
      for (int n = 0; n < 16; n++) wa[n] = -256;
      for (int n = 0; n < 4; n++) ba[n] = 0;
      run_pass(0, 0, 0);
      for (int n = 0; n < 4; n++) begin
         cmp("lit_relu", 0, got[0][n], 0);
         cmp("lit_signed", 1, got[1][n], -1024);
      end

      // Saturation in both directions.
      for (int n = 0; n < 4; n++) begin ina[n] = 32512; ba[n] = 32512; end
      for (int n = 0; n < 16; n++) wa[n] = 32512;
      run_pass(0, 0, 0);
      cmp("lit_sat_pos", 1, got[1][0], 32767);
      cmp("lit_sat_pos_relu", 0, got[0][3], 32767);
      for (int n = 0; n < 16; n++) wa[n] = -32512;
      run_pass(0, 0, 0);
      cmp("lit_sat_neg", 1, got[1][2], -32768);
      cmp("lit_sat_neg_relu", 0, got[0][1], 0);

      // Argmax with a tie: results 5, 9, 9, -3 -> index 1 wins.
      res4 = '{5, 9, 9, -3};
      for (int n = 0; n < 16; n++) wa[n] = 0;
      for (int n = 0; n < 4; n++) ba[n] = res4[n];
      run_pass(0, 0, 0);
      cmp("lit_tie_val3", 1, got[1][3], -3);
      repeat (5) @(negedge Clk);
      cmp("lit_tie_max_idx", 1, s_mi, 1);
      cmp("lit_tie_max_val", 1, s_mv, 9);
      cmp("lit_tie_relu_max_idx", 0, r_mi, 1);

      // Randomized passes, some with a start pulse while busy.
      for (int t = 0; t < 4; t++) begin
         for (int n = 0; n < 4; n++) begin ina[n] = rnd(t[0]); ba[n] = rnd(t[0]); end
         for (int n = 0; n < 16; n++) wa[n] = rnd(t[1]);
         run_pass(0, (t == 1) ? 6 : 0, 0);
      end

      // Reset during the MAC of neuron 1, then a clean full pass.
      run_pass(0, 0, 9);
      for (int n = 0; n < 4; n++) begin ina[n] = rnd(1'b0); ba[n] = rnd(1'b0); end
      for (int n = 0; n < 16; n++) wa[n] = rnd(1'b0);
      run_pass(0, 0, 0);

      // Single-input engine: r = bias + weight when input is 1.0.
      inb[0] = 256;
      wb = '{256, 512, -256};
      bb = '{0, 256, 0};
      run_pass(1, 2, 0);
      cmp("lit_nin1_r0", 2, got[2][0], 256);
      cmp("lit_nin1_r1", 2, got[2][1], 768);
      cmp("lit_nin1_r2", 2, got[2][2], -256);
      cmp("lit_nin1_done_cycle", 2, done_cyc[2], 13);
      cmp("lit_nin1_max_idx", 2, p_mi, 1);
      for (int t = 0; t < 3; t++) begin
         inb[0] = rnd(1'b1);
         for (int n = 0; n < 3; n++) begin wb[n] = rnd(1'b1); bb[n] = rnd(1'b1); end
         run_pass(1, (t == 0) ? 5 : 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
